// File: rtl/controle_tiros.sv
// rtl/controle_tiros.sv - shot processing stage ahead of the scoring block
// Optional build macro: TIRO_EXTRA_EN (a hit lets the same player fire again)
module controle_tiros #(
  parameter int TAM  = 6,
  parameter int NCEL = TAM * TAM
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            carga,
  input  logic            carga_jogador,
  input  logic [NCEL-1:0] carga_navios,
  input  logic            inicio,
  input  logic            tiro_valido,
  output logic            tiro_pronto,
  input  logic [2:0]      tiro_linha,
  input  logic [2:0]      tiro_coluna,
  output logic            vez,
  output logic            resultado_valido,
  output logic            resultado_acerto,
  output logic            resultado_repetido,
  output logic            resultado_invalido,
  output logic [NCEL-1:0] dadosA,
  output logic [NCEL-1:0] dadosB,
  output logic            enabled,
  output logic            fim_jogo,
  output logic            vencedor
);

  localparam int         IW  = $clog2(NCEL);
  localparam logic [2:0] LIM = 3'(TAM);

  typedef enum logic [2:0] {CARGA, ESPERA, VERIFICA, RESULTADO, FIM} estado_t;

  estado_t         estado, prox;
  logic [NCEL-1:0] navios_a, navios_b, tiros_a, tiros_b;
  logic [NCEL-1:0] prox_navios_a, prox_navios_b;
  logic [NCEL-1:0] alvo_tiros, alvo_navios, alvo_dados, mascara;
  logic [2:0]      linha_r, coluna_r;
  logic [IW-1:0]   idx;
  logic            fora, acerto_r, repetido_r, invalido_r, tiro_novo, afundou;

  // Shared decode: post-load ship maps, target board selection and shot index
  always_comb begin
    prox_navios_a = (carga && !carga_jogador) ? carga_navios : navios_a;
    prox_navios_b = (carga &&  carga_jogador) ? carga_navios : navios_b;
    idx           = IW'(32'(linha_r) * TAM + 32'(coluna_r));
    fora          = (linha_r >= LIM) || (coluna_r >= LIM);
    alvo_tiros    = vez ? tiros_a  : tiros_b;
    alvo_navios   = vez ? navios_a : navios_b;
    alvo_dados    = vez ? dadosA   : dadosB;
    mascara       = {{(NCEL-1){1'b0}}, 1'b1} << idx;
    tiro_novo     = !repetido_r && !invalido_r;
    afundou       = tiro_novo && (alvo_dados == alvo_navios);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= CARGA;
    else        estado <= prox;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    prox               = estado;
    tiro_pronto        = 1'b0;
    resultado_valido   = 1'b0;
    fim_jogo           = 1'b0;
    case (estado)
      CARGA: begin
        if (inicio && (|prox_navios_a) && (|prox_navios_b)) prox = ESPERA;
      end
      ESPERA: begin
        tiro_pronto = 1'b1;
        if (tiro_valido) prox = VERIFICA;
      end
      VERIFICA: prox = RESULTADO;
      RESULTADO: begin
        resultado_valido = 1'b1;
        prox             = afundou ? FIM : ESPERA;
      end
      FIM: fim_jogo = 1'b1;
      default: prox = CARGA;
    endcase
    resultado_acerto   = resultado_valido && acerto_r;
    resultado_repetido = resultado_valido && repetido_r;
    resultado_invalido = resultado_valido && invalido_r;
    enabled            = resultado_valido && tiro_novo;
  end

  // Maps, shot registers, turn and winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      navios_a   <= '0;
      navios_b   <= '0;
      tiros_a    <= '0;
      tiros_b    <= '0;
      dadosA     <= '0;
      dadosB     <= '0;
      linha_r    <= '0;
      coluna_r   <= '0;
      acerto_r   <= 1'b0;
      repetido_r <= 1'b0;
      invalido_r <= 1'b0;
      vez        <= 1'b0;
      vencedor   <= 1'b0;
    end else begin
      case (estado)
        CARGA: begin
          navios_a <= prox_navios_a;
          navios_b <= prox_navios_b;
          if (prox == ESPERA) vez <= 1'b0;
        end
        ESPERA: begin
          if (tiro_valido) begin
            linha_r  <= tiro_linha;
            coluna_r <= tiro_coluna;
          end
        end
        VERIFICA: begin
          acerto_r   <= 1'b0;
          repetido_r <= 1'b0;
          invalido_r <= fora;
          if (!fora) begin
            if (alvo_tiros[idx]) begin
              repetido_r <= 1'b1;
            end else begin
              acerto_r <= alvo_navios[idx];
              if (vez) begin
                tiros_a <= tiros_a | mascara;
                dadosA  <= navios_a & (tiros_a | mascara);
              end else begin
                tiros_b <= tiros_b | mascara;
                dadosB  <= navios_b & (tiros_b | mascara);
              end
            end
          end
        end
        RESULTADO: begin
          if (afundou) begin
            vencedor <= vez;
          end else if (tiro_novo) begin
`ifdef TIRO_EXTRA_EN
            if (!acerto_r) vez <= ~vez;
`else
            vez <= ~vez;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_tiros.sv
// tb/tb_controle_tiros.sv - scoreboard bench for controle_tiros
module tb_controle_tiros;
  localparam int TAM  = 6;
  localparam int NCEL = TAM * TAM;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            carga = 1'b0, carga_jogador = 1'b0, inicio = 1'b0, tiro_valido = 1'b0;
  logic [NCEL-1:0] carga_navios = '0;
  logic [2:0]      tiro_linha = '0, tiro_coluna = '0;
  logic            tiro_pronto, vez, resultado_valido, resultado_acerto;
  logic            resultado_repetido, resultado_invalido, enabled, fim_jogo, vencedor;
  logic [NCEL-1:0] dadosA, dadosB;

  controle_tiros #(.TAM(TAM)) dut (
    .clk(clk), .rst_n(rst_n), .carga(carga), .carga_jogador(carga_jogador),
    .carga_navios(carga_navios), .inicio(inicio), .tiro_valido(tiro_valido),
    .tiro_pronto(tiro_pronto), .tiro_linha(tiro_linha), .tiro_coluna(tiro_coluna),
    .vez(vez), .resultado_valido(resultado_valido), .resultado_acerto(resultado_acerto),
    .resultado_repetido(resultado_repetido), .resultado_invalido(resultado_invalido),
    .dadosA(dadosA), .dadosB(dadosB), .enabled(enabled), .fim_jogo(fim_jogo),
    .vencedor(vencedor)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit              acerto;
    bit              rep;
    bit              inv;
    bit              en;
    logic [NCEL-1:0] da;
    logic [NCEL-1:0] db;
    bit              vez;
    bit              fim;
    bit              venc;
  } exp_t;

  exp_t sb[$];
  exp_t pe;
  bit   pend = 1'b0;

  // Reference game state: board 0 = A, board 1 = B
  bit navios[2][NCEL];
  bit tiros[2][NCEL];
  bit m_vez, m_jogo, m_fim;

  task automatic chk(input string nome, input logic [63:0] atual, input logic [63:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
    end
  endtask

  task automatic falha(input string nome);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected expected event", nome);
  endtask

  function automatic logic [NCEL-1:0] acertos(input int j);
    logic [NCEL-1:0] r = '0;
    for (int i = 0; i < NCEL; i++) r[i] = navios[j][i] && tiros[j][i];
    return r;
  endfunction

  function automatic bit frota_afundada(input int j);
    for (int i = 0; i < NCEL; i++) if (navios[j][i] && !tiros[j][i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int contar(input int j);
    int n = 0;
    for (int i = 0; i < NCEL; i++) n += int'(navios[j][i]);
    return n;
  endfunction

  task automatic modelo_reset();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < NCEL; i++) begin
        navios[j][i] = 1'b0;
        tiros[j][i]  = 1'b0;
      end
    m_vez = 0; m_jogo = 0; m_fim = 0;
  endtask

  task automatic aplicar(input int l, input int c);
    exp_t e;
    int   alvo = m_vez ? 0 : 1;
    e = '{default: 0};
    if (l >= TAM || c >= TAM) e.inv = 1;
    else begin
      int i = l * TAM + c;
      if (tiros[alvo][i]) e.rep = 1;
      else begin
        tiros[alvo][i] = 1;
        e.acerto = navios[alvo][i];
        e.en = 1;
        if (frota_afundada(alvo)) begin
          m_fim  = 1;
          e.venc = m_vez;
        end else begin
`ifdef TIRO_EXTRA_EN
          if (!e.acerto) m_vez = !m_vez;
`else
          m_vez = !m_vez;
`endif
        end
      end
    end
    e.da = acertos(0); e.db = acertos(1); e.vez = m_vez; e.fim = m_fim;
    sb.push_back(e);
  endtask

  task automatic reiniciar();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    modelo_reset();
    sb.delete();
    rst_n = 1'b1;
  endtask

  task automatic carregar(input bit j, input logic [NCEL-1:0] mapa, input bit ini);
    @(negedge clk);
    carga = 1; carga_jogador = j; carga_navios = mapa; inicio = ini;
    @(posedge clk);
    #1 carga = 0; inicio = 0;
    for (int i = 0; i < NCEL; i++) navios[j][i] = mapa[i];
    if (ini && !m_jogo && contar(0) > 0 && contar(1) > 0) begin
      m_jogo = 1; m_vez = 0;
    end
  endtask

  task automatic disparar(input int l, input int c, input bit registra);
    int espera = 0;
    @(negedge clk);
    while (!tiro_pronto && espera < 20) begin
      @(negedge clk);
      espera++;
    end
    if (!tiro_pronto) begin
      falha("tiro_pronto_timeout");
      return;
    end
    tiro_valido = 1; tiro_linha = 3'(l); tiro_coluna = 3'(c);
    @(posedge clk);
    #1 tiro_valido = 0;
    if (registra) aplicar(l, c);
  endtask

  task automatic drenar();
    int n = 0;
    while ((sb.size() != 0 || pend) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || pend) falha("drain_timeout");
  endtask

  function automatic logic [NCEL-1:0] mapa_aleatorio();
    logic [63:0]     a, b, c;
    logic [NCEL-1:0] m;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    m = a[NCEL-1:0] & b[NCEL-1:0] & c[NCEL-1:0];
    if (m == '0) m[$urandom_range(0, NCEL-1)] = 1'b1;
    return m;
  endfunction

  // Monitor: pops expected results whenever the DUT presents one
  always @(negedge clk) begin
    if (!rst_n) pend = 0;
    else begin
      if (pend) begin
        chk("vez_after", vez, pe.vez);
        chk("fim_jogo", fim_jogo, pe.fim);
        if (pe.fim) chk("vencedor", vencedor, pe.venc);
        pend = 0;
      end
      if (resultado_valido) begin
        if (sb.size() == 0) falha("unexpected_resultado");
        else begin
          pe = sb.pop_front();
          chk("acerto", resultado_acerto, pe.acerto);
          chk("repetido", resultado_repetido, pe.rep);
          chk("invalido", resultado_invalido, pe.inv);
          chk("enabled", enabled, pe.en);
          chk("dadosA", dadosA, pe.da);
          chk("dadosB", dadosB, pe.db);
          pend = 1;
        end
      end else if (enabled) falha("enabled_without_resultado");
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vistos;
    int l, c, n;
    modelo_reset();
    reiniciar();
    chk("rst_tiro_pronto", tiro_pronto, 0);
    chk("rst_vez", vez, 0);
    chk("rst_dadosA", dadosA, 0);
    chk("rst_dadosB", dadosB, 0);
    chk("rst_fim", fim_jogo, 0);
    chk("rst_enabled", enabled, 0);
    chk("rst_resultado", resultado_valido, 0);
    chk("rst_vencedor", vencedor, 0);

    // Game 1: start refused with B empty, then load+start in one cycle, single winning shot
    carregar(0, 36'h1, 1);
    repeat (3) @(negedge clk);
    chk("inicio_ignorado", tiro_pronto, 0);
    carregar(1, 36'h8_0000_0000, 1);
    @(negedge clk);
    chk("start_pronto", tiro_pronto, 1);
    chk("start_vez", vez, 0);
    chk("start_dadosB", dadosB, 0);
    chk("start_fim", fim_jogo, 0);
    disparar(5, 5, 1);
    drenar();
    @(negedge clk);
    tiro_valido = 1; tiro_linha = 3'd0; tiro_coluna = 3'd0;
    repeat (4) @(negedge clk);
    tiro_valido = 0;
    chk("fim_pronto", tiro_pronto, 0);
    chk("fim_level", fim_jogo, 1);
    chk("fim_vencedor", vencedor, 0);

    // Game 2: miss, invalid, repeated, hits
    reiniciar();
    carregar(0, 36'h1, 0);
    carregar(1, 36'h3, 1);
    disparar(0, 2, 1);
    disparar(6, 0, 1);
    disparar(0, 1, 1);
    disparar(0, 2, 1);
    disparar(0, 0, 1);
    n = 0;
    while (!m_fim && n < 200) begin
      disparar($urandom_range(0, 1), $urandom_range(0, 2), 1);
      n++;
    end
    drenar();

    // Reset while the shot is in VERIFICA aborts without a result
    reiniciar();
    carregar(0, 36'h5, 0);
    carregar(1, 36'h6, 1);
    disparar(0, 1, 0);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_pronto", tiro_pronto, 0);
    chk("abort_resultado", resultado_valido, 0);
    chk("abort_enabled", enabled, 0);
    chk("abort_dadosB", dadosB, 0);
    chk("abort_vez", vez, 0);
    chk("abort_fim", fim_jogo, 0);
    vistos = 0;
    repeat (2) @(negedge clk);
    modelo_reset();
    rst_n = 1;
    repeat (6) begin
      @(negedge clk);
      vistos += int'(resultado_valido);
    end
    chk("abort_no_result", vistos, 0);
    chk("abort_in_carga", tiro_pronto, 0);

    // Randomised games
    for (int g = 0; g < 6; g++) begin
      reiniciar();
      carregar(0, mapa_aleatorio(), 0);
      carregar(1, mapa_aleatorio(), 1);
      n = 0;
      while (!m_fim && n < 150) begin
        l = $urandom_range(0, 6);
        c = $urandom_range(0, 6);
        disparar(l, c, 1);
        n++;
      end
      drenar();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/controle_tiros.md
Name: controle_tiros

Overview:
- Shot-processing stage that sits directly upstream of the scoring block.
- Holds both players' ship maps and shot maps, and accepts one shot per turn through a valid/ready handshake.
- Resolves each shot as hit, miss, repeated or invalid, and produces the per-player hit maps dadosA/dadosB.
- After every map update it pulses enabled to the scoring block and detects end of game.

Parameters:
- TAM, 6: board side length; board is TAM*TAM cells, bit index = linha*TAM + coluna.
- NCEL, TAM*TAM (36): derived; width of all map vectors.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- carga  in  1  load strobe for a ship map; honoured only in CARGA
- carga_jogador  in  1  0 = load player A ships, 1 = player B
- carga_navios  in  NCEL  ship map being loaded, 1 = ship cell
- inicio  in  1  start game; honoured only in CARGA
- tiro_valido  in  1  shot offered by current player
- tiro_pronto  out  1  block ready to accept a shot
- tiro_linha  in  3  row of shot
- tiro_coluna  in  3  column of shot
- vez  out  1  0 = A fires at B's board, 1 = B fires at A's board
- resultado_valido  out  1  one-cycle pulse, result fields valid
- resultado_acerto  out  1  shot hit a ship
- resultado_repetido  out  1  cell already shot
- resultado_invalido  out  1  coordinate out of range
- dadosA  out  NCEL  hits received by A's board (naviosA & tirosEmA)
- dadosB  out  NCEL  hits received by B's board
- enabled  out  1  one-cycle pulse to scoring after map update
- fim_jogo  out  1  level, game over
- vencedor  out  1  0 = A won, 1 = B won; valid when fim_jogo = 1

Behaviour:
- Reset (async, rst_n = 0):
  - State = CARGA.
  - Ship and shot maps all 0.
  - vez = 0, tiro_pronto = 0, all resultado_* = 0, enabled = 0, fim_jogo = 0, vencedor = 0.
  - dadosA = dadosB = 0.
- Reset asserted mid-game aborts immediately; no pending result or enabled pulse is emitted.
- State CARGA:
  - carga = 1 writes carga_navios into the selected player's ship map on that edge.
  - Multiple loads allowed; the last one wins.
  - inicio = 1 moves to ESPERA with vez = 0. If carga and inicio occur in the same cycle, the load is applied and then the game starts.
  - inicio with either ship map all-zero is ignored; the block stays in CARGA.
- State ESPERA:
  - tiro_pronto = 1.
  - A shot is accepted on a clock edge where tiro_valido & tiro_pronto. Coordinates are registered and the block goes to VERIFICA.
  - tiro_pronto drops the cycle after acceptance.
- State VERIFICA (1 cycle):
  - Compute idx = linha*TAM + coluna, 6-bit, no wrap.
  - If linha >= TAM or coluna >= TAM: invalid.
  - Else, if the target shot bit is already 1: repeated.
  - Else: set the target shot bit; acerto = target ship bit.
- State RESULTADO (1 cycle):
  - resultado_valido = 1 with exactly one of acerto / miss (all flags 0) / repetido / invalido.
  - enabled = 1 only for a new (non-repeated, valid) shot, i.e. the cycle after the map update, so dadosA/dadosB are already current.
  - Invalid or repeated shot: turn is kept, back to ESPERA.
  - Otherwise, if the target's hit map equals its ship map, go to FIM.
  - Otherwise toggle vez (see optional feature) and go to ESPERA.
- Latency: acceptance edge → resultado_valido high 2 cycles later. Minimum accept-to-accept interval is 3 cycles.
- State FIM:
  - fim_jogo = 1; vencedor = shooter of the final shot.
  - tiro_pronto = 0; tiro_valido is ignored.
  - Exit only via reset.
- dadosA/dadosB are registered outputs, updated on the edge leaving VERIFICA.
- Map arithmetic: bitwise AND only, width NCEL; no counters overflow.

Optional Feature:
- Macro: TIRO_EXTRA_EN.
- Defined: a valid new shot that hits keeps vez unchanged, so the same player fires again; misses toggle vez.
- Not defined: vez toggles after every valid new shot, hit or miss.
- Invalid and repeated shots never toggle vez in either build.

Test Plan:
- Reset then load A = bit0 only, B = bit35 only, inicio → tiro_pronto = 1, vez = 0, dadosA = dadosB = 0, fim_jogo = 0.
- A fires (5,5) → 2 cycles later resultado_valido & resultado_acerto = 1, dadosB = bit35, enabled = 1 for one cycle, fim_jogo = 1, vencedor = 0.
- B ships = 0x3, A fires (0,2) → miss flags all 0, enabled pulse; vez toggles to 1 without TIRO_EXTRA_EN. The same stimulus with TIRO_EXTRA_EN on a hit at (0,0) → vez stays 0.
- A fires (6,0) → resultado_invalido = 1, no enabled pulse, maps unchanged, vez = 0.
- Repeat an already-shot cell → resultado_repetido = 1, no enabled pulse, vez unchanged.
- Assert rst_n = 0 during VERIFICA → same cycle: all outputs at reset values, state CARGA, no resultado_valido afterwards.
